// File: rtl/nor_gate_checker.sv
// nor_gate_checker: self-test monitor comparing a NOR gate's X/Y/Z outputs against ~(A|B).
// Define NOR_CHK_FIRST_FAIL_EN to build the first-failure capture (index and {a,b,x,y,z}).
module nor_gate_checker #(
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 8,
    parameter int LAT         = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             x_in,
    input  logic             y_in,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [4:0]       first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             run_start_s;
    logic             acc_s;
    logic             exp_in_s;
    logic             cmp_vld_s;
    logic             cmp_exp_s;
    logic             cmp_en_s;
    logic             fail_s;
`ifdef NOR_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] cmp_idx_s;
    logic [1:0]       cmp_ab_s;
`endif

    assign run_start_s = start && ((state_q == IDLE) || (state_q == DONE));
    assign acc_s       = (state_q == RUN) && sample_valid && (acc_cnt_q != NUM_C);
    assign exp_in_s    = ~(a_in | b_in);

    generate
        if (LAT == 0) begin : g_nolat
            assign cmp_vld_s = acc_s;
            assign cmp_exp_s = exp_in_s;
`ifdef NOR_CHK_FIRST_FAIL_EN
            assign cmp_idx_s = acc_cnt_q;
            assign cmp_ab_s  = {a_in, b_in};
`endif
        end else begin : g_pipe
            logic [LAT-1:0]   vld_q, vld_d;
            logic [LAT-1:0]   exp_q, exp_d;
`ifdef NOR_CHK_FIRST_FAIL_EN
            logic [CNT_W-1:0] idx_q [LAT];
            logic [CNT_W-1:0] idx_d [LAT];
            logic [1:0]       ab_q  [LAT];
            logic [1:0]       ab_d  [LAT];
`endif

            // Delay line: stage 0 takes the accepted stimulus, last stage feeds the compare.
            always_comb begin
                vld_d = vld_q;
                exp_d = exp_q;
`ifdef NOR_CHK_FIRST_FAIL_EN
                idx_d = idx_q;
                ab_d  = ab_q;
`endif
                for (int i = LAT - 1; i > 0; i--) begin
                    vld_d[i] = vld_q[i-1];
                    exp_d[i] = exp_q[i-1];
`ifdef NOR_CHK_FIRST_FAIL_EN
                    idx_d[i] = idx_q[i-1];
                    ab_d[i]  = ab_q[i-1];
`endif
                end
                exp_d[0] = exp_in_s;
`ifdef NOR_CHK_FIRST_FAIL_EN
                idx_d[0] = acc_cnt_q;
                ab_d[0]  = {a_in, b_in};
`endif
                if (run_start_s) begin
                    vld_d = {LAT{1'b0}};
                end else begin
                    vld_d[0] = acc_s;
                end
            end

            // Delay line registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= {LAT{1'b0}};
                    exp_q <= {LAT{1'b0}};
`ifdef NOR_CHK_FIRST_FAIL_EN
                    for (int i = 0; i < LAT; i++) begin
                        idx_q[i] <= {CNT_W{1'b0}};
                        ab_q[i]  <= 2'b00;
                    end
`endif
                end else begin
                    vld_q <= vld_d;
                    exp_q <= exp_d;
`ifdef NOR_CHK_FIRST_FAIL_EN
                    for (int i = 0; i < LAT; i++) begin
                        idx_q[i] <= idx_d[i];
                        ab_q[i]  <= ab_d[i];
                    end
`endif
                end
            end

            assign cmp_vld_s = vld_q[LAT-1];
            assign cmp_exp_s = exp_q[LAT-1];
`ifdef NOR_CHK_FIRST_FAIL_EN
            assign cmp_idx_s = idx_q[LAT-1];
            assign cmp_ab_s  = ab_q[LAT-1];
`endif
        end
    endgenerate

    assign cmp_en_s = cmp_vld_s && ((state_q == RUN) || (state_q == DRAIN));
    assign fail_s   = (x_in != cmp_exp_s) || (y_in != cmp_exp_s) || (z_in != cmp_exp_s);

    // Counters and next-state; a run start overrides everything with the clears.
    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (acc_s) begin
            acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_cnt_d = acc_cnt_q;
        end

        if (cmp_en_s) begin
            sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fail_s && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (run_start_s) begin
                    state_d      = RUN;
                    acc_cnt_d    = {CNT_W{1'b0}};
                    sample_cnt_d = {CNT_W{1'b0}};
                    err_cnt_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (sample_cnt_d == NUM_C) begin
                    state_d = DONE;
                end else if (acc_cnt_d == NUM_C) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (sample_cnt_d == NUM_C) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_cnt_d == {CNT_W{1'b0}});
    end

    // Control state, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_cnt_q    <= {CNT_W{1'b0}};
            sample_cnt_q <= {CNT_W{1'b0}};
            err_cnt_q    <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;

`ifdef NOR_CHK_FIRST_FAIL_EN
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [4:0]       ff_vec_q, ff_vec_d;

    // First failure of the run is the failing compare seen while err_cnt is still zero.
    always_comb begin
        ff_idx_d = ff_idx_q;
        ff_vec_d = ff_vec_q;
        if (run_start_s) begin
            ff_idx_d = {CNT_W{1'b0}};
            ff_vec_d = 5'b00000;
        end else if (cmp_en_s && fail_s && (err_cnt_q == {CNT_W{1'b0}})) begin
            ff_idx_d = cmp_idx_s;
            ff_vec_d = {cmp_ab_s, x_in, y_in, z_in};
        end else begin
            ff_idx_d = ff_idx_q;
            ff_vec_d = ff_vec_q;
        end
    end

    // First-failure capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_idx_q <= {CNT_W{1'b0}};
            ff_vec_q <= 5'b00000;
        end else begin
            ff_idx_q <= ff_idx_d;
            ff_vec_q <= ff_vec_d;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_vec = ff_vec_q;
`else
    assign first_fail_idx = {CNT_W{1'b0}};
    assign first_fail_vec = 5'b00000;
`endif

endmodule

// File: tb/tb_nor_gate_checker.sv
// Directed testbench for nor_gate_checker: three instances cover LAT=0/16, LAT=2/16 and LAT=0/8.
module tb_nor_gate_checker;

`ifdef NOR_CHK_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Instance 0: LAT=0, 16 samples, gate with optional Y fault (Y = A|B).
    logic       start0, sv0, a0, b0, x0, y0, z0, y_fault0;
    logic       busy0, done0, pass0;
    logic [7:0] sc0, ec0, ffi0;
    logic [4:0] ffv0;
    assign x0 = ~(a0 | b0);
    assign y0 = y_fault0 ? (a0 | b0) : ~(a0 | b0);
    assign z0 = ~(a0 | b0);

    // Instance 2: LAT=2, gate outputs registered twice.
    logic       start2, sv2, a2, b2, x2, y2, z2, g1, g2;
    logic       busy2, done2, pass2;
    logic [7:0] sc2, ec2, ffi2;
    logic [4:0] ffv2;
    always @(posedge clk) begin
        g1 <= ~(a2 | b2);
        g2 <= g1;
    end
    assign x2 = g2;
    assign y2 = g2;
    assign z2 = g2;

    // Instance 8: LAT=0, 8 samples, Z stuck at 0 (wrong only for input 00).
    logic       start8, sv8, a8, b8, x8, y8, z8;
    logic       busy8, done8, pass8;
    logic [7:0] sc8, ec8, ffi8;
    logic [4:0] ffv8;
    assign x8 = ~(a8 | b8);
    assign y8 = ~(a8 | b8);
    assign z8 = 1'b0;

    nor_gate_checker #(.NUM_SAMPLES(16), .CNT_W(8), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sample_valid(sv0),
        .a_in(a0), .b_in(b0), .x_in(x0), .y_in(y0), .z_in(z0),
        .busy(busy0), .done(done0), .pass(pass0), .sample_cnt(sc0), .err_cnt(ec0),
        .first_fail_idx(ffi0), .first_fail_vec(ffv0));

    nor_gate_checker #(.NUM_SAMPLES(16), .CNT_W(8), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sample_valid(sv2),
        .a_in(a2), .b_in(b2), .x_in(x2), .y_in(y2), .z_in(z2),
        .busy(busy2), .done(done2), .pass(pass2), .sample_cnt(sc2), .err_cnt(ec2),
        .first_fail_idx(ffi2), .first_fail_vec(ffv2));

    nor_gate_checker #(.NUM_SAMPLES(8), .CNT_W(8), .LAT(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sample_valid(sv8),
        .a_in(a8), .b_in(b8), .x_in(x8), .y_in(y8), .z_in(z8),
        .busy(busy8), .done(done8), .pass(pass8), .sample_cnt(sc8), .err_cnt(ec8),
        .first_fail_idx(ffi8), .first_fail_vec(ffv8));

    // pat 0: scrambled A/B pairs; pat 1: sweep 00,01,10,11 repeated.
    function automatic logic [1:0] vec(input int pat, input int i);
        int v;
        v = (pat == 0) ? (i * 3 + i / 4) : i;
        return v[1:0];
    endfunction

    // Full 16-sample run on instance 0; optional extra start pulse at sample restart_at.
    task automatic run0(input int pat, input int restart_at, output int busy_cyc);
        busy_cyc = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start0   = (i == restart_at) ? 1'b1 : 1'b0;
            busy_cyc = busy_cyc + int'(busy0);
            sv0      = 1'b1;
            {a0, b0} = vec(pat, i);
        end
        @(negedge clk);
        sv0    = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", done0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %0d want 0", pass0); end
        n_cmp++; if (sc0 !== 8'd0) begin n_bad++; $display("FAIL reset_sample_cnt: got %0d want 0", sc0); end
        n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", ec0); end
        n_cmp++; if (ffi0 !== 8'd0) begin n_bad++; $display("FAIL reset_ff_idx: got %0d want 0", ffi0); end
        n_cmp++; if (ffv0 !== 5'd0) begin n_bad++; $display("FAIL reset_ff_vec: got %0d want 0", ffv0); end
        rst_n = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start0   = 1'b0;
            sv0      = 1'b1;
            {a0, b0} = vec(0, i);
        end
        @(posedge clk);
        #2;
        n_cmp++; if (sc0 !== 8'd5) begin n_bad++; $display("FAIL midrun_sample_cnt: got %0d want 5", sc0); end
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %0d want 1", busy0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %0d want 0", busy0); end
        n_cmp++; if (sc0 !== 8'd0) begin n_bad++; $display("FAIL async_reset_sample_cnt: got %0d want 0", sc0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL async_reset_done: got %0d want 0", done0); end
        sv0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct();
        int bc;
        y_fault0 = 1'b0;
        run0(0, -1, bc);
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL correct_done: got %0d want 1", done0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL correct_busy_low: got %0d want 0", busy0); end
        n_cmp++; if (sc0 !== 8'd16) begin n_bad++; $display("FAIL correct_sample_cnt: got %0d want 16", sc0); end
        n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL correct_err_cnt: got %0d want 0", ec0); end
        n_cmp++; if (pass0 !== 1'b1) begin n_bad++; $display("FAIL correct_pass: got %0d want 1", pass0); end
        n_cmp++; if (bc != 16) begin n_bad++; $display("FAIL correct_busy_cycles: got %0d want 16", bc); end
    endtask

    task automatic test_faulty_y();
        int bc;
        y_fault0 = 1'b1;
        run0(1, -1, bc);
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL fy_done: got %0d want 1", done0); end
        n_cmp++; if (ec0 !== 8'd16) begin n_bad++; $display("FAIL fy_err_cnt: got %0d want 16", ec0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL fy_pass: got %0d want 0", pass0); end
        n_cmp++; if (ffi0 !== 8'd0) begin n_bad++; $display("FAIL fy_ff_idx: got %0d want 0", ffi0); end
        // {a,b,x,y,z} for input 00 with Y = A|B is 0,0,1,0,1
        n_cmp++; if (ffv0 !== (FF_EN ? 5'b00101 : 5'b00000)) begin
            n_bad++; $display("FAIL fy_ff_vec: got %b want %b", ffv0, (FF_EN ? 5'b00101 : 5'b00000));
        end
    endtask

    task automatic test_latency();
        int acc;
        int c;
        int drain;
        acc = 0;
        c   = 0;
        drain = 0;
        @(negedge clk);
        start2 = 1'b1;
        while (acc < 16 && c < 64) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c % 3 == 2) begin
                sv2 = 1'b0;
            end else begin
                sv2      = 1'b1;
                {a2, b2} = vec(0, acc);
                acc++;
            end
            c++;
        end
        @(negedge clk);
        sv2 = 1'b0;
        n_cmp++; if (sc2 !== 8'd14) begin n_bad++; $display("FAIL lat_inflight_sample_cnt: got %0d want 14", sc2); end
        for (int k = 0; k < 10; k++) begin
            if (done2 === 1'b1) break;
            if (busy2 === 1'b1) drain++;
            @(negedge clk);
        end
        n_cmp++; if (drain != 2) begin n_bad++; $display("FAIL lat_drain_cycles: got %0d want 2", drain); end
        n_cmp++; if (done2 !== 1'b1) begin n_bad++; $display("FAIL lat_done: got %0d want 1", done2); end
        n_cmp++; if (sc2 !== 8'd16) begin n_bad++; $display("FAIL lat_sample_cnt: got %0d want 16", sc2); end
        n_cmp++; if (ec2 !== 8'd0) begin n_bad++; $display("FAIL lat_err_cnt: got %0d want 0", ec2); end
        n_cmp++; if (pass2 !== 1'b1) begin n_bad++; $display("FAIL lat_pass: got %0d want 1", pass2); end
    endtask

    task automatic test_stuck_z();
        @(negedge clk);
        start8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8   = 1'b0;
            sv8      = 1'b1;
            {a8, b8} = vec(1, 3 - (i % 4));
        end
        @(negedge clk);
        sv8 = 1'b0;
        n_cmp++; if (done8 !== 1'b1) begin n_bad++; $display("FAIL sz_done: got %0d want 1", done8); end
        n_cmp++; if (sc8 !== 8'd8) begin n_bad++; $display("FAIL sz_sample_cnt: got %0d want 8", sc8); end
        n_cmp++; if (ec8 !== 8'd2) begin n_bad++; $display("FAIL sz_err_cnt: got %0d want 2", ec8); end
        n_cmp++; if (pass8 !== 1'b0) begin n_bad++; $display("FAIL sz_pass: got %0d want 0", pass8); end
        n_cmp++; if (ffi8 !== (FF_EN ? 8'd3 : 8'd0)) begin
            n_bad++; $display("FAIL sz_ff_idx: got %0d want %0d", ffi8, (FF_EN ? 8'd3 : 8'd0));
        end
        n_cmp++; if (ffv8 !== (FF_EN ? 5'b00110 : 5'b00000)) begin
            n_bad++; $display("FAIL sz_ff_vec: got %b want %b", ffv8, (FF_EN ? 5'b00110 : 5'b00000));
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        y_fault0 = 1'b1;
        run0(1, 5, bc);
        n_cmp++; if (sc0 !== 8'd16) begin n_bad++; $display("FAIL b2b_start_in_run_cnt: got %0d want 16", sc0); end
        n_cmp++; if (ec0 !== 8'd16) begin n_bad++; $display("FAIL b2b_start_in_run_err: got %0d want 16", ec0); end
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %0d want 1", done0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sv0      = 1'b1;
            {a0, b0} = vec(1, i);
        end
        @(negedge clk);
        sv0 = 1'b0;
        n_cmp++; if (sc0 !== 8'd16) begin n_bad++; $display("FAIL b2b_valid_in_done_cnt: got %0d want 16", sc0); end
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_in_done: got %0d want 1", done0); end
        run0(1, -1, bc);
        n_cmp++; if (sc0 !== 8'd16) begin n_bad++; $display("FAIL b2b_rerun_cnt: got %0d want 16", sc0); end
        n_cmp++; if (ec0 !== 8'd16) begin n_bad++; $display("FAIL b2b_rerun_err: got %0d want 16", ec0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL b2b_rerun_pass: got %0d want 0", pass0); end
        n_cmp++; if (bc != 16) begin n_bad++; $display("FAIL b2b_rerun_busy_cycles: got %0d want 16", bc); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        y_fault0 = 1'b0;
        {start0, sv0, a0, b0} = 4'b0000;
        {start2, sv2, a2, b2} = 4'b0000;
        {start8, sv8, a8, b8} = 4'b0000;
        test_reset();
        test_correct();
        test_faulty_y();
        test_latency();
        test_stuck_z();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
